// File: rtl/lsu_split.sv
// Load/store unit: turns a core memory-stage request into one or two aligned
// valid/ready memory beats and returns a lane-merged, extended load result.
module lsu_split #(
    parameter int unsigned ADDR_W           = 32,
    parameter bit          MISALIGNED_SPLIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_trap,
    output logic              o_mem_valid,
    input  logic              i_mem_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [3:0]        o_mem_mask,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE0,
        WAIT0,
        ISSUE1,
        WAIT1,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic              wen_q, wen_d;
    logic              unsigned_q, unsigned_d;
    logic              trap_q, trap_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       d0_q, d0_d;
    logic [31:0]       d1_q, d1_d;

    logic [2:0]  span_end;
    logic        crossing;
    logic        misaligned;
    logic [7:0]  lane_mask;
    logic [63:0] wide_wdata;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic        beat1;

    // Byte lanes and store data laid out over two consecutive words;
    // the upper half is only used by the second beat of a crossing access.
    always_comb begin
        span_end   = {1'b0, off_q} + nbytes_q;
        crossing   = span_end > 3'd4;
        lane_mask  = ((8'h01 << nbytes_q) - 8'h01) << off_q;
        wide_wdata = {32'h0, wdata_q} << {off_q, 3'b000};
        merged     = 32'({d1_q, d0_q} >> {off_q, 3'b000});
        case (nbytes_q)
            3'd1:    load_ext = unsigned_q ? {24'h0, merged[7:0]}
                                           : {{24{merged[7]}}, merged[7:0]};
            3'd2:    load_ext = unsigned_q ? {16'h0, merged[15:0]}
                                           : {{16{merged[15]}}, merged[15:0]};
            default: load_ext = merged;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wen_q      <= 1'b0;
            unsigned_q <= 1'b0;
            trap_q     <= 1'b0;
            off_q      <= '0;
            nbytes_q   <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
        end else begin
            wen_q      <= wen_d;
            unsigned_q <= unsigned_d;
            trap_q     <= trap_d;
            off_q      <= off_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wen_d      = wen_q;
        unsigned_d = unsigned_q;
        trap_d     = trap_q;
        off_d      = off_q;
        nbytes_d   = nbytes_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        misaligned = (i_req_size == 2'b01 && i_req_addr[0]) ||
                     (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    wen_d      = i_req_wen;
                    unsigned_d = i_req_unsigned;
                    off_d      = i_req_addr[1:0];
                    base_d     = {i_req_addr[ADDR_W-1:2], 2'b00};
                    wdata_d    = i_req_wdata;
                    trap_d     = 1'b0;
                    case (i_req_size)
                        2'b00:   nbytes_d = 3'd1;
                        2'b01:   nbytes_d = 3'd2;
                        default: nbytes_d = 3'd4;
                    endcase
                    if (i_req_size == 2'b11 || (misaligned && !MISALIGNED_SPLIT)) begin
                        trap_d  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE0;
                    end
                end
            end
            ISSUE0: begin
                if (i_mem_ready) begin
                    if (!wen_q)        state_d = WAIT0;
                    else if (crossing) state_d = ISSUE1;
                    else               state_d = RESP;
                end
            end
            WAIT0: begin
                if (i_mem_rvalid) begin
                    d0_d    = i_mem_rdata;
                    state_d = crossing ? ISSUE1 : RESP;
                end
            end
            ISSUE1: begin
                if (i_mem_ready) state_d = wen_q ? RESP : WAIT1;
            end
            WAIT1: begin
                if (i_mem_rvalid) begin
                    d1_d    = i_mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        beat1       = state_q == ISSUE1;
        o_req_ready = state_q == IDLE;
        o_mem_valid = state_q == ISSUE0 || state_q == ISSUE1;
        o_mem_ren   = o_mem_valid && !wen_q;
        o_mem_wen   = o_mem_valid && wen_q;
        o_mem_addr  = '0;
        o_mem_mask  = '0;
        o_mem_wdata = '0;
        if (o_mem_valid) begin
            o_mem_addr = beat1 ? base_q + ADDR_W'(4) : base_q;
            o_mem_mask = beat1 ? lane_mask[7:4] : lane_mask[3:0];
        end
        if (o_mem_wen) begin
            o_mem_wdata = beat1 ? wide_wdata[63:32] : wide_wdata[31:0];
        end
        o_rsp_valid = state_q == RESP;
        o_rsp_trap  = o_rsp_valid && trap_q;
        o_rsp_rdata = (o_rsp_valid && !trap_q && !wen_q) ? load_ext : '0;
    end

endmodule

// File: doc/lsu_split.md
# lsu_split

Load/store unit sitting between the hart's memory stage and a latency-tolerant data memory port. It replaces the combinational single-cycle dmem access with a valid/ready request/response handshake. It computes aligned address, byte mask and lane-shifted write data, and sign/zero-extends load data. Selectable by parameter, it either traps on misaligned accesses or splits word-crossing accesses into two memory beats and merges the results.

## Interface
- ADDR_W, 32: address width; beat-1 address wraps modulo 2^ADDR_W.
- MISALIGNED_SPLIT, 0: 0 = any misaligned access traps; 1 = misaligned accesses are performed, split when crossing a word.
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_req_valid / o_req_ready  in/out  1  core request handshake; accepted when both are high.
- i_req_wen  in  1  1 = store, 0 = load.
- i_req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal (traps).
- i_req_unsigned  in  1  load zero-extends when set.
- i_req_addr  in  ADDR_W  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- o_rsp_valid / i_rsp_ready  out/in  1  response handshake.
- o_rsp_rdata  out  32  extended load result; 0 for stores and traps.
- o_rsp_trap  out  1  misaligned (MISALIGNED_SPLIT=0) or illegal size.
- o_mem_valid / i_mem_ready  out/in  1  memory request handshake.
- o_mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- o_mem_ren, o_mem_wen  out  1  never both high; both 0 when o_mem_valid is 0.
- o_mem_mask  out  4  byte lanes.
- o_mem_wdata  out  32  lane-shifted store data.
- i_mem_rvalid / i_mem_rdata  in  1/32  read return, at least 1 cycle after acceptance; one return per accepted read, in order.

## Operation
- States: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: o_req_ready=1. On accept, latch the operation and compute off = addr[1:0] and n = 1/2/4 bytes.
  - If size=11, go to RESP with trap.
  - If misaligned (half with off[0]=1, word with off≠0) and MISALIGNED_SPLIT=0, go to RESP with trap. No memory access is made.
  - Otherwise go to ISSUE0.
- Crossing: off+n > 4. Only possible when MISALIGNED_SPLIT=1. A half at off=1 is misaligned but not crossing, so it is a single beat with mask 0110.
- Beat 0:
  - addr = addr & ~3.
  - mask covers bytes off..min(off+n,4)-1.
  - wdata = wdata << 8*off.
- Beat 1:
  - addr = beat0 addr + 4.
  - mask covers bytes 0..off+n-5.
  - wdata = wdata >> 8*(4-off).
- ISSUE0: hold o_mem_valid and all mem fields stable until i_mem_ready.
  - Load: go to WAIT0.
  - Store: go to ISSUE1 if crossing, else RESP.
- WAIT0: on i_mem_rvalid, capture rdata into d0, then go to ISSUE1 if crossing, else RESP.
- ISSUE1 / WAIT1: same as ISSUE0 / WAIT0, capturing d1, then go to RESP.
- Load merge: r = ({d1,d0} >> 8*off). Keep the low n bytes, then sign- or zero-extend to 32 bits.
- RESP: o_rsp_valid=1 with rdata and trap held stable until i_rsp_ready, then go to IDLE.
- i_mem_rvalid outside WAIT0/WAIT1 is ignored.
- One operation in flight at a time.

## Timing
- Reset (i_rst_n low at an edge) gives:
  - state IDLE, o_req_ready=1
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_trap=0
  - o_mem_valid=0, o_mem_ren=0, o_mem_wen=0, o_mem_mask=0, o_mem_addr=0, o_mem_wdata=0
- Reset mid-operation abandons the operation. A read return arriving afterwards is dropped.
- All outputs are driven from state and registers; nothing combinational from inputs to outputs.
- Aligned load, with i_mem_ready=1 and rvalid 1 cycle after acceptance:
  - accept at edge 0, ISSUE0 in cycle 1, WAIT0 in cycle 2, o_rsp_valid in cycle 3.
- Aligned store under the same conditions: o_rsp_valid in cycle 2.
- Trap: o_rsp_valid in cycle 1.
- Each extra cycle of i_mem_ready low, rvalid delay, or i_rsp_ready low adds exactly one cycle.

## Test plan
- Aligned lw 0x1000, mem returns 0xDEADBEEF -> mask 1111, addr 0x1000, rsp 0xDEADBEEF, trap 0, response in cycle 3.
- lb 0x2003 with mem word 0x80FFFFFF, and lbu at the same address -> mask 1000, rdata 0xFFFFFF80 and 0x00000080 respectively.
- sh 0x2002, wdata 0x1234ABCD -> mask 1100, o_mem_wdata[31:16]=0xABCD, wen=1, ren=0.
- MISALIGNED_SPLIT=0: lw 0x1001 -> no o_mem_valid, trap 1, rdata 0 in cycle 1. Size 11 also traps in both modes.
- MISALIGNED_SPLIT=1 crossing cases:
  - lw 0x1003 with words 0x44332211 at 0x1000 and 0x88776655 at 0x1004 -> beats at 0x1000 (mask 1000) and 0x1004 (mask 0111), rdata 0x77665544.
  - sw 0xFFFFFFFE -> beat 1 addr wraps to 0x0.
- i_mem_ready low for 3 cycles and i_rsp_ready low for 2 cycles -> fields held stable; reset asserted during WAIT0 -> returns to IDLE and the late rvalid is ignored.
